axis_sum_controller: RTL

- Sequences the four-channel complex summing datapath: performs the AXI-stream join across channels 00/01/20/21 and issues a single advance strobe when every enabled channel holds a beat and the sink can accept.
- Counts beats per frame and generates the frame-end tlast.
- Checks tlast alignment across channels and re-synchronises after a misalignment.
- Sits between the per-channel weighting stages and the summing datapath. It is configured by a PS-side register block.

---
 rtl/axis_sum_pkg.sv | 19 +
 rtl/axis_frame_counter.sv | 56 +++++
 rtl/axis_sum_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/axis_sum_pkg.sv
// Shared types and defaults for the four-channel complex summing controller.
package axis_sum_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int COUNT_WIDTH_DEF = 16;

  // Channel stream indices within the joined vectors
  localparam int CH00 = 0;
  localparam int CH01 = 1;
  localparam int CH20 = 2;
  localparam int CH21 = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_e;

endpackage

// File: rtl/axis_frame_counter.sv
// Beat-within-frame and completed-frame counters with the last-beat compare.
module axis_frame_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr_all,
  input  logic                   clr_beat,
  input  logic                   fire,
  input  logic                   misalign,
  input  logic [COUNT_WIDTH-1:0] frame_len,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   last_beat
);

  logic [COUNT_WIDTH-1:0] beat_q, beat_d;
  logic [COUNT_WIDTH-1:0] frame_q, frame_d;

  assign last_beat   = (beat_q == frame_len - COUNT_WIDTH'(1));
  assign beat_count  = beat_q;
  assign frame_count = frame_q;

  // Next-count logic: a misaligned beat restarts the frame without counting it as complete
  always_comb begin
    beat_d  = beat_q;
    frame_d = frame_q;
    if (clr_all) begin
      beat_d  = '0;
      frame_d = '0;
    end else if (clr_beat) begin
      beat_d = '0;
    end else if (fire) begin
      if (misalign) begin
        beat_d = '0;
      end else if (last_beat) begin
        beat_d  = '0;
        frame_d = frame_q + COUNT_WIDTH'(1);
      end else begin
        beat_d = beat_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_q  <= '0;
      frame_q <= '0;
    end else begin
      beat_q  <= beat_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/axis_sum_controller.sv
// Joins the four channel streams, issues the datapath advance strobe, frames
// the output with tlast and re-synchronises channels after tlast misalignment.
module axis_sum_controller
  import axis_sum_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_tvalid,
  input  logic [NUM_CH-1:0]      ch_tlast,
  output logic [NUM_CH-1:0]      ch_tready,
  input  logic                   sum_tready,
  output logic                   sum_fire,
  output logic                   sum_tlast,
  output logic [NUM_CH-1:0]      sum_mask,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [NUM_CH-1:0]      cfg_mask,
  input  logic [COUNT_WIDTH-1:0] cfg_frame_len,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   err_misalign,
  output logic                   err_cfg
);

  state_e                 state_q, state_d;
  logic [NUM_CH-1:0]      sum_mask_q, sum_mask_d;
  logic [NUM_CH-1:0]      seen_last_q, seen_last_d;
  logic [COUNT_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                   err_misalign_q, err_misalign_d;
  logic                   err_cfg_q, err_cfg_d;
  logic                   stop_pending_q, stop_pending_d;

  logic                   all_joined, fire, misalign, last_beat, stop_req;
  logic                   cnt_clr_all, cnt_clr_beat;
  logic [NUM_CH-1:0]      seen_next;

  // Join and advance: disabled channels never hold up the sum
  always_comb begin
    all_joined = &(ch_tvalid | ~sum_mask_q);
    fire       = (state_q == RUN) && all_joined && sum_tready;
    misalign   = fire && (|(sum_mask_q & (ch_tlast ^ {NUM_CH{last_beat}})));
  end

  assign sum_fire     = fire;
  assign sum_tlast    = fire & last_beat;
  assign sum_mask     = sum_mask_q;
  assign busy         = (state_q != IDLE);
  assign err_misalign = err_misalign_q;
  assign err_cfg      = err_cfg_q;

  // Per-channel ready: enabled channels pop together on fire, disabled ones drain freely
  always_comb begin
    ch_tready = '0;
    case (state_q)
      RUN:     ch_tready = (sum_mask_q & {NUM_CH{fire}}) | ~sum_mask_q;
      RESYNC:  ch_tready = ~(sum_mask_q & seen_last_q);
      default: ch_tready = '0;
    endcase
  end

  // Next-state and control updates
  always_comb begin
    state_d        = state_q;
    sum_mask_d     = sum_mask_q;
    seen_last_d    = seen_last_q;
    frame_len_d    = frame_len_q;
    err_misalign_d = err_misalign_q;
    err_cfg_d      = err_cfg_q;
    stop_pending_d = stop_pending_q;
    cnt_clr_all    = 1'b0;
    cnt_clr_beat   = 1'b0;
    stop_req       = stop_pending_q | cfg_stop;
    seen_next      = seen_last_q | (ch_tvalid & ch_tready & ch_tlast & sum_mask_q);
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if ((cfg_mask != '0) && (cfg_frame_len != '0)) begin
            sum_mask_d     = cfg_mask;
            frame_len_d    = cfg_frame_len;
            err_misalign_d = 1'b0;
            err_cfg_d      = 1'b0;
            stop_pending_d = 1'b0;
            seen_last_d    = '0;
            cnt_clr_all    = 1'b1;
            state_d        = RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      RUN: begin
        stop_pending_d = stop_req;
        if (misalign) begin
          err_misalign_d = 1'b1;
          seen_last_d    = sum_mask_q & ch_tlast;
          state_d        = RESYNC;
        end else if (stop_req && ((fire && last_beat) || (!fire && (beat_count == '0)))) begin
          stop_pending_d = 1'b0;
          state_d        = IDLE;
        end
      end
      RESYNC: begin
        stop_pending_d = stop_req;
        seen_last_d    = seen_next;
        if ((seen_next & sum_mask_q) == sum_mask_q) begin
          seen_last_d  = '0;
          cnt_clr_beat = 1'b1;
          if (stop_req) begin
            stop_pending_d = 1'b0;
            state_d        = IDLE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sum_mask_q     <= '0;
      seen_last_q    <= '0;
      frame_len_q    <= '0;
      err_misalign_q <= 1'b0;
      err_cfg_q      <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_mask_q     <= sum_mask_d;
      seen_last_q    <= seen_last_d;
      frame_len_q    <= frame_len_d;
      err_misalign_q <= err_misalign_d;
      err_cfg_q      <= err_cfg_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  axis_frame_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_frame_counter (
    .clock      (clock),
    .reset      (reset),
    .clr_all    (cnt_clr_all),
    .clr_beat   (cnt_clr_beat),
    .fire       (fire),
    .misalign   (misalign),
    .frame_len  (frame_len_q),
    .beat_count (beat_count),
    .frame_count(frame_count),
    .last_beat  (last_beat)
  );

endmodule
